// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed scan front end for a 7-segment decoder. A packed BCD
//   value is double-buffered in a shadow register and committed to the
//   display register only at the frame boundary, so a frame never tears.
//   Each digit slot lasts PRESCALE clocks, and the slots are scanned from
//   digit 0 upward. Leading zeros (optional) and nibbles > 9 are blanked.
//
// Ports
//   clk    : single clock, rising edge
//   rst    : synchronous active-high reset
//   load   : one-cycle request to capture `value`
//   value  : packed BCD, nibble i = digit i
//   digit  : BCD digit for the current slot (forced to 0 when blanked)
//   sel    : one-hot digit select, bit i = digit i
//   blank  : current slot must be dark
//   ack    : one-cycle pulse when a value was committed to the display
//   err    : sticky flag, a committed value held a nibble > 9
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            digit,
  output logic [DIGITS-1:0]     sel,
  output logic                  blank,
  output logic                  ack,
  output logic                  err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = $clog2(DIGITS);
  localparam logic [PW-1:0] PC_MAX   = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(DIGITS - 1);

  logic [PW-1:0]         pc_q, pc_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [4*DIGITS-1:0]   shd_q, shd_d;
  logic                  pend_q, pend_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [3:0]            digit_q, digit_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  blank_q, blank_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  boundary;
  logic                  commit;
  logic [4*DIGITS-1:0]   commit_val;
  logic [DIGITS-1:0]     commit_bad;
  logic [DIGITS-1:0]     nib_zero;
  logic [DIGITS-1:0]     upper_zero;
  logic [3:0]            nib [DIGITS];

  // Scan counters, shadow buffer and commit.
  always_comb begin
    boundary   = (pc_q == PC_MAX) && (slot_q == SLOT_MAX);
    pc_d       = (pc_q == PC_MAX) ? '0 : pc_q + 1'b1;
    slot_d     = slot_q;
    if (pc_q == PC_MAX) begin
      slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
    end
    // A load in the boundary cycle bypasses the shadow register.
    commit     = boundary && (load || pend_q);
    commit_val = load ? value : shd_q;
    shd_d      = shd_q;
    pend_d     = pend_q;
    if (boundary) begin
      pend_d = 1'b0;
    end else if (load) begin
      shd_d  = value;
      pend_d = 1'b1;
    end
    disp_d = commit ? commit_val : disp_q;
    ack_d  = commit;
    err_d  = err_q | (commit & (|commit_bad));
  end

  // Per-nibble helpers; outputs are decoded from the next-state display and
  // slot so a commit shows up in slot 0 on the very edge it happens.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib[gi]        = disp_d[4*gi +: 4];
    assign nib_zero[gi]   = (disp_d[4*gi +: 4] == 4'd0);
    assign upper_zero[gi] = &nib_zero[DIGITS-1:gi];
    assign commit_bad[gi] = (commit_val[4*gi +: 4] > 4'd9);
    assign sel_d[gi]      = (slot_d == SW'(gi));
  end

  always_comb begin
    logic [3:0] n;
    logic       lz;
    n  = 4'd0;
    lz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_d == SW'(i)) begin
        n  = nib[i];
        lz = upper_zero[i];
      end
    end
    blank_d = (n > 4'd9) || ((BLANK_LZ != 0) && (slot_d != '0) && lz);
    digit_d = blank_d ? 4'd0 : n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      slot_q  <= '0;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      disp_q  <= '0;
      digit_q <= 4'd0;
      sel_q   <= DIGITS'(1);
      blank_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      slot_q  <= slot_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      digit_q <= digit_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign digit = digit_q;
  assign sel   = sel_q;
  assign blank = blank_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver (DIGITS=4, PRESCALE=4, BLANK_LZ=1)
// against a cycle-count based reference model of the display behaviour.
module tb_seg7_scan_driver;

  localparam int D   = 4;
  localparam int P   = 4;
  localparam int BLZ = 1;
  localparam int FRAME = D * P;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic [4*D-1:0]  value = '0;
  logic [3:0]      digit;
  logic [D-1:0]    sel;
  logic            blank;
  logic            ack;
  logic            err;

  seg7_scan_driver #(.DIGITS(D), .PRESCALE(P), .BLANK_LZ(BLZ)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (value),
    .digit (digit),
    .sel   (sel),
    .blank (blank),
    .ack   (ack),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles since reset, committed value, pending value.
  int           k = 0;
  logic [15:0]  m_disp = '0;
  logic [15:0]  m_shd  = '0;
  bit           m_pend = 0;
  bit           m_ack  = 0;
  bit           m_err  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  function automatic bit has_bad(input logic [15:0] v);
    for (int i = 0; i < D; i++)
      if (((v >> (4*i)) & 16'hF) > 9) return 1;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit ld, input logic [15:0] v);
    if (r) begin
      k = 0; m_disp = 0; m_shd = 0; m_pend = 0; m_ack = 0; m_err = 0;
      return;
    end
    m_ack = 0;
    if ((k % FRAME) == FRAME - 1) begin
      if (ld || m_pend) begin
        m_disp = ld ? v : m_shd;
        m_ack  = 1;
        if (has_bad(m_disp)) m_err = 1;
        $display("commit value=%04h at k=%0d", m_disp, k);
      end
      m_pend = 0;
    end else if (ld) begin
      m_shd  = v;
      m_pend = 1;
    end
    k++;
  endtask

  task automatic check_outputs();
    int s;
    logic [15:0] upper;
    logic [3:0]  n;
    bit          eb;
    s     = (k / P) % D;
    upper = m_disp >> (4*s);
    n     = upper[3:0];
    eb    = (n > 9) || (BLZ != 0 && s != 0 && upper == 0);
    check_eq("sel",   32'(sel),   32'(1 << s));
    check_eq("blank", 32'(blank), 32'(eb));
    check_eq("digit", 32'(digit), eb ? 32'd0 : 32'(n));
    check_eq("ack",   32'(ack),   32'(m_ack));
    check_eq("err",   32'(err),   32'(m_err));
  endtask

  task automatic cycle(input bit r, input bit ld, input logic [15:0] v);
    rst = r; load = ld; value = v;
    if (ld && !r) $display("load value=%04h at k=%0d", v, k);
    @(posedge clk);
    model_step(r, ld, v);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < D; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r < 4)       v[4*i +: 4] = 4'd0;
      else if (r == 15) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else             v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    // Reset and a plain scan of one frame.
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    idle(16);

    // Load in the middle of the first frame after reset.
    cycle(1, 0, '0);
    idle(3);
    cycle(0, 1, 16'h1234);
    idle(20);

    // Leading-zero blanking.
    cycle(0, 1, 16'h0050);
    idle(32);

    // Last load before the boundary wins.
    cycle(0, 1, 16'h1111);
    idle(2);
    cycle(0, 1, 16'h2222);
    idle(32);

    // Load exactly in the boundary cycle, invalid nibble, sticky err.
    while ((k % FRAME) != FRAME - 1) cycle(0, 0, '0);
    cycle(0, 1, 16'h00A7);
    idle(20);
    cycle(0, 1, 16'h0123);
    idle(32);

    // Reset mid-frame discards a pending value.
    cycle(0, 1, 16'h9999);
    idle(5);
    cycle(1, 0, '0);
    idle(20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      bit r, ld;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 19) == 0);
      cycle(r, ld, rand_value());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
